// File: rtl/latency_absorb_pkg.sv
// latency_absorb_pkg -- shared constants and helpers for the latency absorber.
//   MAX_DEPTH  : largest storage depth the block supports
//   CNT_W      : width of the occupancy / in-flight counters (holds 0..MAX_DEPTH)
//   ptr_width  : read/write pointer width for a given depth (at least 1 bit)
package latency_absorb_pkg;

  localparam int MAX_DEPTH = 128;
  localparam int CNT_W     = $clog2(MAX_DEPTH + 1);

  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/latency_absorb_mem.sv
// latency_absorb_mem -- DEPTH x DW storage array, one synchronous write port and
// one asynchronous read port. Contents are not reset.
//   i_clk   : clock
//   i_we    : write enable
//   i_waddr : write address
//   i_wdata : write data
//   i_raddr : read address
//   o_rdata : read data (combinational from i_raddr)
module latency_absorb_mem
  import latency_absorb_pkg::*;
#(
  parameter int DW    = 8,
  parameter int DEPTH = 5,
  parameter int PW    = ptr_width(DEPTH)
) (
  input  logic          i_clk,
  input  logic          i_we,
  input  logic [PW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic [PW-1:0] i_raddr,
  output logic [DW-1:0] o_rdata
);

  logic [DW-1:0] r_mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/latency_absorb.sv
// latency_absorb -- credit-based skid store behind a fixed-latency pipeline.
// Upstream may launch only while stored + in-flight items fit in DEPTH, so every
// item that emerges from the pipeline tail always has a slot waiting for it.
//   clk       : clock, rising edge
//   rst_n     : synchronous active-low reset
//   up_valid  : upstream wants to launch an item into the pipeline
//   up_ready  : launch permitted (credit available)
//   in_valid  : item arrives from the pipeline tail
//   din       : arriving item data
//   out_valid : dout holds a valid item
//   out_ready : downstream accepts dout
//   dout      : head-of-queue data
//   err       : sticky flag, arrival seen with nothing in flight
//
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high; valid never depends on ready of the same interface, and dout is held
// stable while out_valid && !out_ready.
module latency_absorb
  import latency_absorb_pkg::*;
#(
  parameter int DW    = 8,
  parameter int LAT   = 4,
  parameter int DEPTH = LAT + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          up_valid,
  output logic          up_ready,
  input  logic          in_valid,
  input  logic [DW-1:0] din,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] dout,
  output logic          err
);

  localparam int             PW       = ptr_width(DEPTH);
  localparam logic [CNT_W:0] DEPTH_C  = (CNT_W + 1)'(DEPTH);
  localparam logic [PW-1:0]  LAST_PTR = PW'(DEPTH - 1);

  if (LAT < 1 || LAT > 64 || DEPTH < 1 || DEPTH > MAX_DEPTH) begin : g_bad_param
    $error("latency_absorb: LAT or DEPTH out of range");
  end

  logic [CNT_W-1:0] r_occ;
  logic [CNT_W-1:0] r_infl;
  logic [PW-1:0]    r_wptr;
  logic [PW-1:0]    r_rptr;
  logic             r_err;

  logic [CNT_W:0]   w_used;
  logic             w_launch;
  logic             w_pop;
  logic             w_arrive;
  logic             w_bad_arrive;

  // Pointers wrap explicitly so DEPTH need not be a power of two.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  // Credit is computed from registered counts only; a same-cycle pop does not
  // free a credit until the next cycle.
  assign w_used       = {1'b0, r_occ} + {1'b0, r_infl};
  assign up_ready     = (w_used < DEPTH_C);
  assign out_valid    = (r_occ != '0);
  assign err          = r_err;

  assign w_launch     = up_valid && up_ready;
  assign w_pop        = out_valid && out_ready;
  // An arrival with nothing in flight cannot belong to a launch we granted.
  assign w_arrive     = in_valid && (r_infl != '0);
  assign w_bad_arrive = in_valid && (r_infl == '0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_occ  <= '0;
      r_infl <= '0;
      r_wptr <= '0;
      r_rptr <= '0;
      r_err  <= 1'b0;
    end else begin
      if (w_launch && !w_arrive) begin
        r_infl <= r_infl + 1'b1;
      end else if (!w_launch && w_arrive) begin
        r_infl <= r_infl - 1'b1;
      end

      if (w_arrive && !w_pop) begin
        r_occ <= r_occ + 1'b1;
      end else if (!w_arrive && w_pop) begin
        r_occ <= r_occ - 1'b1;
      end

      if (w_arrive) begin
        r_wptr <= ptr_inc(r_wptr);
      end
      if (w_pop) begin
        r_rptr <= ptr_inc(r_rptr);
      end

      if (w_bad_arrive) begin
        r_err <= 1'b1;
      end
    end
  end

  latency_absorb_mem #(
    .DW    (DW),
    .DEPTH (DEPTH),
    .PW    (PW)
  ) u_mem (
    .i_clk   (clk),
    .i_we    (w_arrive),
    .i_waddr (r_wptr),
    .i_wdata (din),
    .i_raddr (r_rptr),
    .o_rdata (dout)
  );

endmodule

// File: tb/tb_latency_absorb.sv
module tb_latency_absorb;

  localparam int DW    = 8;
  localparam int LAT   = 4;
  localparam int DEPTH = 5;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          up_valid = 1'b0;
  logic          up_ready;
  logic          in_valid;
  logic [DW-1:0] din;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] dout;
  logic          err;

  logic          inj_valid = 1'b0;
  logic [DW-1:0] up_data = '0;

  latency_absorb #(.DW(DW), .LAT(LAT), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .up_valid  (up_valid),
    .up_ready  (up_ready),
    .in_valid  (in_valid),
    .din       (din),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .dout      (dout),
    .err       (err)
  );

  // ---------------- upstream add_latency model ----------------
  logic          pipe_v [LAT];
  logic [DW-1:0] pipe_d [LAT];

  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < LAT; i++) begin
        pipe_v[i] <= 1'b0;
        pipe_d[i] <= '0;
      end
    end else begin
      pipe_v[0] <= up_valid && up_ready;
      pipe_d[0] <= up_data;
      for (int i = 1; i < LAT; i++) begin
        pipe_v[i] <= pipe_v[i-1];
        pipe_d[i] <= pipe_d[i-1];
      end
    end
  end

  assign in_valid = pipe_v[LAT-1] | inj_valid;
  assign din      = pipe_d[LAT-1];

  // ---------------- scoreboard ----------------
  logic [DW-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int launches = 0;
  int pops = 0;
  logic [DW-1:0] next_data = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d @%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Called just after a falling edge: apply inputs, let combinational outputs
  // settle, record launches and check pops against the expected queue.
  task automatic drive(input logic uv, input logic ordy, input logic inj);
    up_valid  = uv;
    out_ready = ordy;
    inj_valid = inj;
    up_data   = next_data;
    #1;
    if (up_valid && up_ready) begin
      exp_q.push_back(next_data);
      next_data = next_data + 1'b1;
      launches++;
    end
    if (out_valid && out_ready) begin
      pops++;
      if (exp_q.size() == 0) begin
        chk("pop_unexpected", 32'(dout), 32'hFFFF_FFFF);
      end else begin
        chk("dout_order", 32'(dout), 32'(exp_q.pop_front()));
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n     = 1'b0;
    up_valid  = 1'b0;
    out_ready = 1'b0;
    inj_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
    launches  = 0;
    pops      = 0;
    next_data = '0;
  endtask

  task automatic chk_state(input string tag, input logic rdy, input logic ov,
                           input int occ, input int infl, input logic e);
    chk({tag, "_up_ready"},  32'(up_ready),   32'(rdy));
    chk({tag, "_out_valid"}, 32'(out_valid),  32'(ov));
    chk({tag, "_occ"},       32'(dut.r_occ),  32'(occ));
    chk({tag, "_infl"},      32'(dut.r_infl), 32'(infl));
    chk({tag, "_err"},       32'(err),        32'(e));
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic uv;
    logic ordy;
    logic rdy;
    logic ov;
    int   occ;
    int   infl;
  } vec_t;

  vec_t bp_tab [16];

  initial begin
    int first_ov;

    // Backpressure then drain: launch while stalled, then release out_ready.
    bp_tab[0]  = '{1'b1, 1'b0, 1'b1, 1'b0, 0, 0};
    bp_tab[1]  = '{1'b1, 1'b0, 1'b1, 1'b0, 0, 1};
    bp_tab[2]  = '{1'b1, 1'b0, 1'b1, 1'b0, 0, 2};
    bp_tab[3]  = '{1'b1, 1'b0, 1'b1, 1'b0, 0, 3};
    bp_tab[4]  = '{1'b1, 1'b0, 1'b1, 1'b0, 0, 4};
    bp_tab[5]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1, 4};
    bp_tab[6]  = '{1'b1, 1'b0, 1'b0, 1'b1, 2, 3};
    bp_tab[7]  = '{1'b1, 1'b0, 1'b0, 1'b1, 3, 2};
    bp_tab[8]  = '{1'b1, 1'b0, 1'b0, 1'b1, 4, 1};
    bp_tab[9]  = '{1'b1, 1'b0, 1'b0, 1'b1, 5, 0};
    bp_tab[10] = '{1'b0, 1'b1, 1'b0, 1'b1, 5, 0};
    bp_tab[11] = '{1'b0, 1'b1, 1'b1, 1'b1, 4, 0};
    bp_tab[12] = '{1'b0, 1'b1, 1'b1, 1'b1, 3, 0};
    bp_tab[13] = '{1'b0, 1'b1, 1'b1, 1'b1, 2, 0};
    bp_tab[14] = '{1'b0, 1'b1, 1'b1, 1'b1, 1, 0};
    bp_tab[15] = '{1'b0, 1'b1, 1'b1, 1'b0, 0, 0};

    // ---- reset state ----
    do_reset();
    #1;
    chk_state("reset", 1'b1, 1'b0, 0, 0, 1'b0);

    // ---- backpressure / drain table ----
    for (int i = 0; i < 16; i++) begin
      drive(bp_tab[i].uv, bp_tab[i].ordy, 1'b0);
      chk("bp_up_ready",  32'(up_ready),   32'(bp_tab[i].rdy));
      chk("bp_out_valid", 32'(out_valid),  32'(bp_tab[i].ov));
      chk("bp_occ",       32'(dut.r_occ),  32'(bp_tab[i].occ));
      chk("bp_infl",      32'(dut.r_infl), 32'(bp_tab[i].infl));
      tick();
    end
    chk("bp_launches", 32'(launches), 32'd5);
    chk("bp_pops", 32'(pops), 32'd5);
    chk("bp_err", 32'(err), 32'd0);

    // ---- simultaneous arrival + pop at occ = 4, infl = 1 ----
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b0, 1'b0);
      tick();
    end
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, 1'b0);
      tick();
    end
    drive(1'b0, 1'b1, 1'b0);
    chk_state("simul_pre", 1'b0, 1'b1, 4, 1, 1'b0);
    tick();
    drive(1'b0, 1'b0, 1'b0);
    chk_state("simul_post", 1'b1, 1'b1, 4, 0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b1, 1'b0);
      tick();
    end
    drive(1'b0, 1'b0, 1'b0);
    chk("simul_drained", 32'(exp_q.size()), 32'd0);

    // ---- protocol error: arrival with nothing in flight ----
    do_reset();
    drive(1'b1, 1'b0, 1'b0);
    tick();
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b0, 1'b0);
      tick();
    end
    drive(1'b0, 1'b0, 1'b1);
    chk_state("err_pre", 1'b1, 1'b1, 1, 0, 1'b0);
    tick();
    drive(1'b0, 1'b0, 1'b0);
    chk_state("err_set", 1'b1, 1'b1, 1, 0, 1'b1);
    for (int i = 0; i < 3; i++) tick();
    chk("err_sticky", 32'(err), 32'd1);

    // ---- reset mid-operation with occ = 3, infl = 2 (err still set) ----
    drive(1'b0, 1'b1, 1'b0);
    tick();
    for (int i = 0; i < 7; i++) begin
      drive((i < 5) ? 1'b1 : 1'b0, 1'b0, 1'b0);
      tick();
    end
    drive(1'b0, 1'b0, 1'b0);
    chk_state("rstmid_pre", 1'b0, 1'b1, 3, 2, 1'b1);
    do_reset();
    drive(1'b0, 1'b0, 1'b0);
    chk_state("rstmid_post", 1'b1, 1'b0, 0, 0, 1'b0);
    for (int i = 0; i < 6; i++) tick();
    chk_state("rstmid_idle", 1'b1, 1'b0, 0, 0, 1'b0);

    // ---- streaming 0..19 with out_ready held high ----
    do_reset();
    first_ov = -1;
    for (int cyc = 0; cyc < 300 && pops < 20; cyc++) begin
      drive(launches < 20, 1'b1, 1'b0);
      if (out_valid && first_ov < 0) first_ov = cyc;
      tick();
    end
    chk("stream_first_out_valid", 32'(first_ov), 32'd5);
    chk("stream_pops", 32'(pops), 32'd20);
    chk("stream_queue_empty", 32'(exp_q.size()), 32'd0);
    chk("stream_err", 32'(err), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
